// File: rtl/line_draw_pkg.sv
// Shared line-drawer definitions: screen coordinate widths and coordinate types.
package line_draw_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef logic [X_W-1:0] coord_x_t;
    typedef logic [Y_W-1:0] coord_y_t;

endpackage : line_draw_pkg

// File: rtl/abs_diff_if.sv
// Operand/result bundle for abs_diff; the sign signal exists only with ABS_DIFF_SIGN_EN.
interface abs_diff_if
    import line_draw_pkg::*;
#(
    parameter int WIDTH = X_W
);

    logic             in_valid;
    logic [WIDTH-1:0] val_1;
    logic [WIDTH-1:0] val_2;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             is_zero;
    logic [WIDTH-1:0] out_comb;
`ifdef ABS_DIFF_SIGN_EN
    logic             sign;
`endif

    modport master (
        output in_valid, val_1, val_2,
        input  out, out_valid, is_zero, out_comb
`ifdef ABS_DIFF_SIGN_EN
        , input sign
`endif
    );

    modport slave (
        input  in_valid, val_1, val_2,
        output out, out_valid, is_zero, out_comb
`ifdef ABS_DIFF_SIGN_EN
        , output sign
`endif
    );

endinterface : abs_diff_if

// File: rtl/abs_diff_core.sv
// Combinational |val_1 - val_2| of two unsigned operands, plus order and equality flags.
module abs_diff_core
    import line_draw_pkg::*;
#(
    parameter int WIDTH = X_W
) (
    input  logic [WIDTH-1:0] val_1,
    input  logic [WIDTH-1:0] val_2,
    output logic [WIDTH-1:0] diff,
    output logic             lt,
    output logic             eq
);

    logic [WIDTH-1:0] w_d12;
    logic [WIDTH-1:0] w_d21;

    assign w_d12 = val_1 - val_2;
    assign w_d21 = val_2 - val_1;
    assign lt    = (val_1 < val_2);
    assign eq    = (val_1 == val_2);

    // Select the non-wrapping direction so the result always fits in WIDTH bits.
    always_comb begin
        diff = w_d12;
        if (lt) begin
            diff = w_d21;
        end else begin
            diff = w_d12;
        end
    end

endmodule : abs_diff_core

// File: rtl/abs_diff.sv
// Registered absolute difference with valid flag and zero flag.
// Define ABS_DIFF_SIGN_EN to add a registered operand-order (sign) output.
module abs_diff
    import line_draw_pkg::*;
#(
    parameter int WIDTH = X_W
) (
    input  logic        clk,
    input  logic        reset,
    abs_diff_if.slave   bus
);

    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic             w_eq;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_is_zero;

    abs_diff_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .val_1 (bus.val_1),
        .val_2 (bus.val_2),
        .diff  (w_diff),
        .lt    (w_lt),
        .eq    (w_eq)
    );

    // Result register: reset wins over in_valid; idle cycles hold data and drop valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_is_zero   <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r_out       <= w_diff;
            r_is_zero   <= w_eq;
            r_out_valid <= 1'b1;
        end else begin
            r_out       <= r_out;
            r_is_zero   <= r_is_zero;
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.is_zero   = r_is_zero;
    assign bus.out_comb  = w_diff;

`ifdef ABS_DIFF_SIGN_EN
    logic r_sign;

    // Operand-order register, same capture rules as the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
        end else if (bus.in_valid) begin
            r_sign <= w_lt;
        end else begin
            r_sign <= r_sign;
        end
    end

    assign bus.sign = r_sign;
`else
    logic w_unused_lt;
    assign w_unused_lt = w_lt;
`endif

endmodule : abs_diff

// File: tb/tb_abs_diff.sv
// Scoreboard bench for abs_diff at WIDTH=10 and WIDTH=9, run side by side.
module tb_abs_diff;
    import line_draw_pkg::*;

    typedef struct {
        int   out;
        logic z;
        logic s;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t q10[$];
    exp_t q9[$];

    abs_diff_if #(.WIDTH(X_W)) if10 ();
    abs_diff_if #(.WIDTH(Y_W)) if9 ();

    abs_diff #(.WIDTH(X_W)) u_dut10 (.clk(clk), .reset(reset), .bus(if10));
    abs_diff #(.WIDTH(Y_W)) u_dut9  (.clk(clk), .reset(reset), .bus(if9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Drive one cycle on both DUTs, check out_comb, record expectations, advance past the edge.
    task automatic step(input logic rst, input logic v10, input int a10, input int b10,
                        input logic v9, input int a9, input int b9);
        logic [31:0] x10a, x10b, x9a, x9b;
        exp_t e;
        x10a = a10; x10b = b10; x9a = a9; x9b = b9;
        reset         = rst;
        if10.in_valid = v10;
        if10.val_1    = x10a[9:0];
        if10.val_2    = x10b[9:0];
        if9.in_valid  = v9;
        if9.val_1     = x9a[8:0];
        if9.val_2     = x9b[8:0];
        #1;
        check_eq("comb10", {22'd0, if10.out_comb}, absd(a10, b10));
        check_eq("comb9",  {23'd0, if9.out_comb},  absd(a9, b9));
        if (v10 && !rst) begin
            e.out = absd(a10, b10); e.z = (a10 == b10); e.s = (a10 < b10);
            q10.push_back(e);
        end
        if (v9 && !rst) begin
            e.out = absd(a9, b9); e.z = (a9 == b9); e.s = (a9 < b9);
            q9.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if10.out_valid === 1'b1) begin
            if (q10.size() == 0) begin
                check_eq("spurious10", 32'd1, 32'd0);
            end else begin
                e = q10.pop_front();
                check_eq("out10", {22'd0, if10.out}, e.out);
                check_eq("zero10", {31'd0, if10.is_zero}, {31'd0, e.z});
`ifdef ABS_DIFF_SIGN_EN
                check_eq("sign10", {31'd0, if10.sign}, {31'd0, e.s});
`endif
            end
        end
        if (if9.out_valid === 1'b1) begin
            if (q9.size() == 0) begin
                check_eq("spurious9", 32'd1, 32'd0);
            end else begin
                e = q9.pop_front();
                check_eq("out9", {23'd0, if9.out}, e.out);
                check_eq("zero9", {31'd0, if9.is_zero}, {31'd0, e.z});
`ifdef ABS_DIFF_SIGN_EN
                check_eq("sign9", {31'd0, if9.sign}, {31'd0, e.s});
`endif
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out10"},   {22'd0, if10.out}, 32'd0);
        check_eq({tag, "_zero10"},  {31'd0, if10.is_zero}, 32'd1);
        check_eq({tag, "_valid10"}, {31'd0, if10.out_valid}, 32'd0);
        check_eq({tag, "_out9"},    {23'd0, if9.out}, 32'd0);
        check_eq({tag, "_valid9"},  {31'd0, if9.out_valid}, 32'd0);
`ifdef ABS_DIFF_SIGN_EN
        check_eq({tag, "_sign10"},  {31'd0, if10.sign}, 32'd0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if10.in_valid = 1'b0; if10.val_1 = '0; if10.val_2 = '0;
        if9.in_valid  = 1'b0; if9.val_1  = '0; if9.val_2  = '0;

        // Reset held two cycles with a valid input present: input is dropped.
        step(1'b1, 1'b1, 12, 1, 1'b1, 12, 1);
        step(1'b1, 1'b1, 12, 1, 1'b1, 12, 1);
        check_reset_state("rst");

        // Basic result, then back-to-back order-swapped operands on the 9-bit instance.
        step(1'b0, 1'b1, 12, 1, 1'b1, 1, 5);
        check_eq("tp_out11", {22'd0, if10.out}, 32'd11);
        check_eq("tp_valid", {31'd0, if10.out_valid}, 32'd1);
        step(1'b0, 1'b1, 3, 3, 1'b1, 5, 1);
        check_eq("b2b_out4", {23'd0, if9.out}, 32'd4);
        check_eq("b2b_valid", {31'd0, if9.out_valid}, 32'd1);
        check_eq("eq_out0", {22'd0, if10.out}, 32'd0);
        check_eq("eq_zero", {31'd0, if10.is_zero}, 32'd1);

        // Idle cycle: data holds, valid drops.
        step(1'b0, 1'b0, 700, 5, 1'b0, 300, 2);
        check_eq("hold_out", {22'd0, if10.out}, 32'd0);
        check_eq("hold_zero", {31'd0, if10.is_zero}, 32'd1);
        check_eq("hold_valid", {31'd0, if10.out_valid}, 32'd0);
        check_eq("hold_out9", {23'd0, if9.out}, 32'd4);

        // Full-scale and LSB boundaries.
        step(1'b0, 1'b1, 1023, 0, 1'b1, 0, 511);
        check_eq("max10a", {22'd0, if10.out}, 32'd1023);
        check_eq("max9", {23'd0, if9.out}, 32'd511);
        step(1'b0, 1'b1, 0, 1023, 1'b1, 511, 0);
        check_eq("max10b", {22'd0, if10.out}, 32'd1023);
        step(1'b0, 1'b1, 6, 7, 1'b1, 255, 254);
        check_eq("lsb10", {22'd0, if10.out}, 32'd1);
        check_eq("lsb9", {23'd0, if9.out}, 32'd1);

        // Reset mid-stream, then recovery with one-cycle latency.
        step(1'b0, 1'b1, 12, 1, 1'b1, 12, 1);
        check_eq("pre_rst_out", {22'd0, if10.out}, 32'd11);
        step(1'b1, 1'b1, 10, 1, 1'b1, 10, 1);
        check_reset_state("midrst");
        step(1'b0, 1'b1, 10, 1, 1'b1, 10, 1);
        check_eq("post_rst_out", {22'd0, if10.out}, 32'd9);
        check_eq("post_rst_valid", {31'd0, if10.out_valid}, 32'd1);

        // Random traffic with gaps.
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        end
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

        check_eq("drain10", q10.size(), 32'd0);
        check_eq("drain9", q9.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_abs_diff
